branch_unit: RTL and testbench

// - Consumer of the Comparator's zero_flag/carry_flag outputs.
// - Holds the flag register and evaluates conditional jumps (JE/JNE/JB/JAE/JA/JBE/JMP) against it.
// - Owns the program counter and tells the fetch stage when to flush.
// - Flag semantics: Z=1 means number1==number2; C=1 means number1<number2 (unsigned borrow).

---
 rtl/branch_unit_pkg.sv | 21 ++
 rtl/branch_unit_if.sv | 29 ++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/branch_unit.sv | 134 +++++++++++++
 tb/tb_branch_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit slice.
// - Condition codes carried on br_cond (3 bits).
// - FSM state type used by the top.
package branch_unit_pkg;

  localparam logic [2:0] COND_JMP  = 3'b000; // always taken
  localparam logic [2:0] COND_JE   = 3'b001; // Z
  localparam logic [2:0] COND_JNE  = 3'b010; // !Z
  localparam logic [2:0] COND_JB   = 3'b011; // C
  localparam logic [2:0] COND_JAE  = 3'b100; // !C
  localparam logic [2:0] COND_JA   = 3'b101; // !C & !Z
  localparam logic [2:0] COND_JBE  = 3'b110; // C | Z
  localparam logic [2:0] COND_RSVD = 3'b111; // never taken, flagged as bad

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/branch_unit_if.sv
// Branch request handshake between the issuing stage and the branch unit.
// - br_valid  : request present (master -> slave)
// - br_ready  : unit can accept (slave -> master); handshake = valid & ready
// - br_cond   : condition code, sampled at handshake
// - br_target : absolute target address, sampled at handshake
interface branch_unit_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;

  modport master (
    output br_valid,
    output br_cond,
    output br_target,
    input  br_ready
  );

  modport slave (
    input  br_valid,
    input  br_cond,
    input  br_target,
    output br_ready
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator.
// - cond : 3-bit condition code
// - z, c : flag values (Z = operands equal, C = unsigned borrow)
// - take : branch is taken
// - bad  : reserved condition code
module branch_cond_eval
  import branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       c,
  output logic       take,
  output logic       bad
);

  always_comb begin
    take = 1'b0;
    bad  = 1'b0;
    unique case (cond)
      COND_JMP:  take = 1'b1;
      COND_JE:   take = z;
      COND_JNE:  take = ~z;
      COND_JB:   take = c;
      COND_JAE:  take = ~c;
      COND_JA:   take = ~c & ~z;
      COND_JBE:  take = c | z;
      COND_RSVD: bad  = 1'b1;
      default:   bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: owns the flag register and the program counter, resolves
// conditional jumps and tells fetch when to flush.
// Ports:
// - clk, rst        : clock, synchronous active-high reset
// - flag_we         : capture zero_flag_in / carry_flag_in
// - zero_flag_in    : comparator zero flag
// - carry_flag_in   : comparator carry (borrow) flag
// - br              : branch request handshake (slave side)
// - advance         : sequential PC increment request
// - pc              : current program counter
// - taken, flush    : 1-cycle pulse in the resolve cycle of a taken branch
// - bad_cond        : 1-cycle pulse when a reserved condition resolves
// - flags_valid     : flag register written since reset
// - z_q, c_q        : current flag register
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              zero_flag_in,
  input  logic              carry_flag_in,
  branch_unit_if.slave      br,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              flush,
  output logic              bad_cond,
  output logic              flags_valid,
  output logic              z_q,
  output logic              c_q
);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] pc_d;
  logic [2:0]        cond_q;
  logic [ADDR_W-1:0] target_q;
  logic              z_snap, c_snap;
  logic              hs;
  logic              take, bad;
  logic              taken_c, bad_c;

  branch_cond_eval u_eval (
    .cond (cond_q),
    .z    (z_snap),
    .c    (c_snap),
    .take (take),
    .bad  (bad)
  );

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pc_d        = pc;
    hs          = 1'b0;
    taken_c     = 1'b0;
    bad_c       = 1'b0;
    br.br_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        br.br_ready = 1'b1;
        if (br.br_valid) begin
          // Handshake wins over a simultaneous advance.
          hs      = 1'b1;
          state_d = S_RESOLVE;
        end else if (advance) begin
          pc_d = pc + ADDR_W'(1);
        end
      end
      S_RESOLVE: begin
        bad_c = bad;
        if (take) begin
          taken_c = 1'b1;
          pc_d    = target_q;
          cnt_d   = 4'(FLUSH_CYCLES);
          state_d = S_FLUSH;
        end else begin
          pc_d    = pc + ADDR_W'(1);
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt <= 4'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses come straight from the resolve cycle; masking with rst keeps an
  // aborted branch from ever signalling taken/flush.
  assign taken    = taken_c & ~rst;
  assign flush    = taken_c & ~rst;
  assign bad_cond = bad_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc          <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      flags_valid <= 1'b0;
      cond_q      <= COND_JMP;
      target_q    <= '0;
      z_snap      <= 1'b0;
      c_snap      <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pc    <= pc_d;
      if (flag_we) begin
        z_q         <= zero_flag_in;
        c_q         <= carry_flag_in;
        flags_valid <= 1'b1;
      end
      if (hs) begin
        cond_q   <= br.br_cond;
        target_q <= br.br_target;
        // Forward flags written in the handshake cycle into the snapshot.
        z_snap   <= flag_we ? zero_flag_in  : z_q;
        c_snap   <= flag_we ? carry_flag_in : c_q;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;
  import branch_unit_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned FC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flag_we;
  logic          zero_flag_in;
  logic          carry_flag_in;
  logic          advance;
  logic [AW-1:0] pc;
  logic          taken, flush, bad_cond, flags_valid, z_q, c_q;

  int checks   = 0;
  int failures = 0;
  logic [AW-1:0] exp_pc;

  branch_unit_if #(.ADDR_W(AW)) bif ();

  branch_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .rst           (rst),
    .flag_we       (flag_we),
    .zero_flag_in  (zero_flag_in),
    .carry_flag_in (carry_flag_in),
    .br            (bif),
    .advance       (advance),
    .pc            (pc),
    .taken         (taken),
    .flush         (flush),
    .bad_cond      (bad_cond),
    .flags_valid   (flags_valid),
    .z_q           (z_q),
    .c_q           (c_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic z, input logic c);
    flag_we = 1'b1; zero_flag_in = z; carry_flag_in = c;
    tick();
    flag_we = 1'b0;
    chk("flag_z", 32'(z_q), 32'(z));
    chk("flag_c", 32'(c_q), 32'(c));
  endtask

  // Handshake one branch and follow it back to IDLE.
  task automatic do_branch(input string tag, input logic [2:0] cond,
                           input logic [AW-1:0] tgt, input logic exp_take,
                           input logic exp_bad);
    bif.br_valid = 1'b1; bif.br_cond = cond; bif.br_target = tgt;
    tick();
    bif.br_valid = 1'b0;
    chk({tag, "_taken"}, 32'(taken), 32'(exp_take));
    chk({tag, "_flush"}, 32'(flush), 32'(exp_take));
    chk({tag, "_bad"},   32'(bad_cond), 32'(exp_bad));
    chk({tag, "_rdy_r"}, 32'(bif.br_ready), 32'd0);
    chk({tag, "_pc_r"},  32'(pc), 32'(exp_pc));
    tick();
    exp_pc = exp_take ? tgt : exp_pc + AW'(1);
    chk({tag, "_pc"},    32'(pc), 32'(exp_pc));
    chk({tag, "_pulse_off"}, 32'({taken, flush, bad_cond}), 32'd0);
    if (exp_take) begin
      for (int i = 0; i < int'(FC); i++) begin
        chk({tag, "_rdy_fl"}, 32'(bif.br_ready), 32'd0);
        tick();
      end
    end
    chk({tag, "_rdy"}, 32'(bif.br_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; zero_flag_in = 1'b0; carry_flag_in = 1'b0;
    advance = 1'b0; bif.br_valid = 1'b0; bif.br_cond = '0; bif.br_target = '0;
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ready", 32'(bif.br_ready), 32'd1);
    chk("rst_pulses", 32'({taken, flush, bad_cond}), 32'd0);
    chk("rst_flags", 32'({flags_valid, z_q, c_q}), 32'd0);
    rst = 1'b0;

    // T1: JE taken at pc=3
    set_flags(1'b1, 1'b0);
    chk("t1_fv", 32'(flags_valid), 32'd1);
    advance = 1'b1;
    tick(); tick(); tick();
    advance = 1'b0;
    exp_pc = AW'(3);
    chk("t1_pc3", 32'(pc), 32'd3);
    do_branch("t1_je", COND_JE, AW'('h155), 1'b1, 1'b0);

    // T2: number1<number2 -> JA not taken, JB taken
    set_flags(1'b0, 1'b1);
    do_branch("t2_ja", COND_JA, AW'('h020), 1'b0, 1'b0);
    chk("t2_pc156", 32'(pc), 32'h156);
    do_branch("t2_jb", COND_JB, AW'('h020), 1'b1, 1'b0);

    // T3: forwarded Z=1 makes JNE not taken; later Z=0 write ignored
    bif.br_valid = 1'b1; bif.br_cond = COND_JNE; bif.br_target = AW'('h2AA);
    flag_we = 1'b1; zero_flag_in = 1'b1; carry_flag_in = 1'b0;
    tick();
    bif.br_valid = 1'b0; zero_flag_in = 1'b0;
    chk("t3_taken", 32'(taken), 32'd0);
    chk("t3_zq_fwd", 32'(z_q), 32'd1);
    tick();
    flag_we = 1'b0;
    chk("t3_pc", 32'(pc), 32'h021);
    chk("t3_zq_late", 32'(z_q), 32'd0);
    chk("t3_ready", 32'(bif.br_ready), 32'd1);
    exp_pc = AW'('h021);

    // Flags now Z=0,C=0: JNE taken to top of address space
    do_branch("jne_top", COND_JNE, AW'('h3FF), 1'b1, 1'b0);

    // T4: wrap and handshake/advance collision
    advance = 1'b1;
    tick();
    exp_pc = '0;
    chk("t4_wrap", 32'(pc), 32'd0);
    do_branch("t4_jae", COND_JAE, AW'('h100), 1'b1, 1'b0);
    advance = 1'b0;
    chk("t4_pc_hold", 32'(pc), 32'h100);

    // Remaining codes on Z=0,C=0
    do_branch("ja_00",  COND_JA,  AW'('h050), 1'b1, 1'b0);
    do_branch("jbe_00", COND_JBE, AW'('h3C0), 1'b0, 1'b0);
    do_branch("je_00",  COND_JE,  AW'('h3C0), 1'b0, 1'b0);
    do_branch("jb_00",  COND_JB,  AW'('h3C0), 1'b0, 1'b0);
    chk("pc_053", 32'(pc), 32'h053);

    // T5: reserved condition
    do_branch("t5_rsvd", COND_RSVD, AW'('h123), 1'b0, 1'b1);
    chk("t5_pc", 32'(pc), 32'h054);

    // rst during RESOLVE suppresses the pulse
    set_flags(1'b1, 1'b1);
    bif.br_valid = 1'b1; bif.br_cond = COND_JMP; bif.br_target = AW'('h200);
    tick();
    bif.br_valid = 1'b0;
    chk("rr_taken_pre", 32'(taken), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_taken_rst", 32'({taken, flush}), 32'd0);
    tick();
    rst = 1'b0;
    chk("rr_pc", 32'(pc), 32'd0);
    chk("rr_ready", 32'(bif.br_ready), 32'd1);
    chk("rr_flags", 32'({flags_valid, z_q, c_q}), 32'd0);
    tick();
    chk("rr_pc_after", 32'(pc), 32'd0);
    chk("rr_no_pulse", 32'({taken, flush}), 32'd0);
    exp_pc = '0;

    // T5b: branches on reset flags with flags_valid=0
    do_branch("t5_jmp", COND_JMP, AW'('h0AA), 1'b1, 1'b0);
    do_branch("nv_ja",  COND_JA,  AW'('h0BB), 1'b1, 1'b0);
    chk("nv_fv", 32'(flags_valid), 32'd0);

    // T6: rst during FLUSH
    set_flags(1'b1, 1'b0);
    bif.br_valid = 1'b1; bif.br_cond = COND_JMP; bif.br_target = AW'('h1C0);
    tick();
    bif.br_valid = 1'b0;
    chk("t6_taken", 32'(taken), 32'd1);
    tick();
    chk("t6_pc_tgt", 32'(pc), 32'h1C0);
    chk("t6_rdy_fl", 32'(bif.br_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_ready", 32'(bif.br_ready), 32'd1);
    chk("t6_fv", 32'(flags_valid), 32'd0);
    chk("t6_pulses", 32'({taken, flush}), 32'd0);
    tick();
    chk("t6_pulses2", 32'({taken, flush}), 32'd0);
    chk("t6_pc2", 32'(pc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
